perm_stream_shuffler: RTL and testbench

Multi-cycle, synthesisable Fisher-Yates permutation generator.
- Builds the identity array 0..N-1 over N cycles.
- Shuffles it with one accepted swap per cycle, drawing indices from a seedable 32-bit LFSR with rejection sampling, so indices are uniform.
- Streams the permutation out over a valid/ready interface.
- Sits between the host control logic and any consumer needing a random ordering, such as address scramblers or test-pattern sequencers.

---
 rtl/perm_stream_shuffler.sv | 145 ++++++++++++++
 tb/tb_perm_stream_shuffler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_stream_shuffler.sv
// Fisher-Yates permutation generator: identity build, LFSR-driven shuffle
// with rejection sampling, then valid/ready streaming of the result.
module perm_stream_shuffler #(
  parameter int          N            = 100,
  parameter int          IW           = (N > 1) ? $clog2(N) : 1,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seed_load,
  input  logic [31:0]   seed,
  input  logic          start,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_SHUF = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] p_q, p_d;
  logic [IW-1:0] out_data_q, out_data_d;
  logic          done_q, done_d;
  logic [IW-1:0] array_q [N];
  logic [IW-1:0] array_d [N];

  logic [IW-1:0] mask;
  logic [IW-1:0] cand;
  logic          accept;
  logic          fb;

  // Smear i downward so the mask covers i's MSB and everything below it.
  always_comb begin
    mask = '0;
    for (int b = 0; b < IW; b++) begin
      mask[b] = |(i_q >> b);
    end
  end

  assign cand   = lfsr_q[IW-1:0] & mask;
  assign accept = (cand <= i_q);
  assign fb     = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    k_d        = k_q;
    i_d        = i_q;
    p_d        = p_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    array_d    = array_q;
    unique case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed == 32'd0) ? SEED_DEFAULT : seed;
        end else if (start) begin
          state_d = S_INIT;
          k_d     = '0;
        end
      end
      S_INIT: begin
        array_d[k_q] = k_q;
        k_d          = k_q + 1'b1;
        if (k_q == LAST) begin
          if (N == 1) begin
            state_d    = S_OUT;
            p_d        = '0;
            out_data_d = '0;
          end else begin
            state_d = S_SHUF;
            i_d     = LAST;
          end
        end
      end
      S_SHUF: begin
        lfsr_d = {lfsr_q[30:0], fb};
        if (accept) begin
          array_d[i_q]  = array_q[cand];
          array_d[cand] = array_q[i_q];
          i_d           = i_q - 1'b1;
          if (i_q == IW'(1)) begin
            state_d    = S_OUT;
            p_d        = '0;
            out_data_d = array_d[0];
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (p_q == LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            p_d        = p_q + 1'b1;
            out_data_d = array_q[p_d];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_DEFAULT;
      k_q        <= '0;
      i_q        <= '0;
      p_q        <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      k_q        <= k_d;
      i_q        <= i_d;
      p_q        <= p_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  // Array contents are don't-care after reset.
  always_ff @(posedge clk) begin
    array_q <= array_d;
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_last  = out_valid & (p_q == LAST);
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_perm_stream_shuffler.sv
// Bench for perm_stream_shuffler: four instances (N=8,16,1,2) checked
// every cycle against a software Fisher-Yates model.
module tb_perm_stream_shuffler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] seed = 32'd0;
  logic [3:0]  sl = 4'd0;
  logic [3:0]  st = 4'd0;
  logic        rdy1 = 1'b1;
  logic [3:0]  rdy;
  logic [3:0]  bz, vl, ls, dn;
  logic [2:0]  d0;
  logic [3:0]  d1;
  logic        d2, d3;

  always #5 clk = ~clk;
  assign rdy = {1'b1, 1'b1, rdy1, 1'b1};

  perm_stream_shuffler #(.N(8)) u8 (
    .clk(clk), .reset(reset), .seed_load(sl[0]), .seed(seed),
    .start(st[0]), .busy(bz[0]), .out_valid(vl[0]), .out_ready(rdy[0]),
    .out_data(d0), .out_last(ls[0]), .done(dn[0]));
  perm_stream_shuffler #(.N(16)) u16 (
    .clk(clk), .reset(reset), .seed_load(sl[1]), .seed(seed),
    .start(st[1]), .busy(bz[1]), .out_valid(vl[1]), .out_ready(rdy[1]),
    .out_data(d1), .out_last(ls[1]), .done(dn[1]));
  perm_stream_shuffler #(.N(1)) u1 (
    .clk(clk), .reset(reset), .seed_load(sl[2]), .seed(seed),
    .start(st[2]), .busy(bz[2]), .out_valid(vl[2]), .out_ready(rdy[2]),
    .out_data(d2), .out_last(ls[2]), .done(dn[2]));
  perm_stream_shuffler #(.N(2)) u2 (
    .clk(clk), .reset(reset), .seed_load(sl[3]), .seed(seed),
    .start(st[3]), .busy(bz[3]), .out_valid(vl[3]), .out_ready(rdy[3]),
    .out_data(d3), .out_last(ls[3]), .done(dn[3]));

  int cmp_n = 0;
  int bad_n = 0;

  logic [31:0] m_lfsr [4];
  bit   m_busy [4];
  bit   m_valid [4];
  bit   m_done [4];
  int   m_cnt [4];
  int   m_p [4];
  int   expv [4][16];
  int   rec [4][16];
  int   rec_n [4];
  int   done_n [4];
  int   last_n [4];
  int   last_at [4];
  bit   hold_v [4];
  int   hold_dat [4];
  bit   bp_on = 1'b0;
  bit   held = 1'b0;
  int   hold_cnt = 0;

  function automatic int nsz(int d);
    case (d)
      0: return 8;
      1: return 16;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int dat(int d);
    case (d)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  function automatic logic [31:0] lnext(logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Smallest all-ones value covering i.
  function automatic int msk(int i);
    int m = 1;
    while (m < i) m = m * 2 + 1;
    return m;
  endfunction

  // Software Fisher-Yates; returns the number of LFSR draws used.
  function automatic int gen(int d);
    int n = nsz(d);
    int i = n - 1;
    int c, t;
    int dr = 0;
    for (int k = 0; k < n; k++) expv[d][k] = k;
    while (i >= 1 && dr < 100000) begin
      c = int'(m_lfsr[d] & 32'(msk(i)));
      m_lfsr[d] = lnext(m_lfsr[d]);
      dr++;
      if (c <= i) begin
        t = expv[d][i];
        expv[d][i] = expv[d][c];
        expv[d][c] = t;
        i--;
      end
    end
    return dr;
  endfunction

  task automatic chk(string nm, int d, int act, int req);
    cmp_n++;
    if (act != req) begin
      bad_n++;
      $display("FAIL %s dut%0d: got %0d required %0d", nm, d, act, req);
    end
  endtask

  // Reference model plus transfer recording.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 4; d++) begin
        m_lfsr[d]  = 32'hACE1;
        m_busy[d]  = 1'b0;
        m_valid[d] = 1'b0;
        m_done[d]  = 1'b0;
        m_cnt[d]   = 0;
        m_p[d]     = 0;
        hold_v[d]  = 1'b0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (vl[d] && rdy[d]) begin
          if (rec_n[d] < 16) rec[d][rec_n[d]] = dat(d);
          rec_n[d]++;
          if (ls[d]) begin
            last_n[d]++;
            last_at[d] = rec_n[d];
          end
        end
        if (dn[d]) done_n[d]++;
        hold_v[d] = vl[d] && !rdy[d];
        hold_dat[d] = dat(d);
        m_done[d] = 1'b0;
        if (!m_busy[d]) begin
          if (sl[d]) m_lfsr[d] = (seed == 32'd0) ? 32'hACE1 : seed;
          else if (st[d]) begin
            m_cnt[d]   = nsz(d) + gen(d);
            m_busy[d]  = 1'b1;
            m_valid[d] = 1'b0;
          end
        end else if (!m_valid[d]) begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin
            m_valid[d] = 1'b1;
            m_p[d]     = 0;
          end
        end else if (rdy[d]) begin
          if (m_p[d] == nsz(d) - 1) begin
            m_busy[d]  = 1'b0;
            m_valid[d] = 1'b0;
            m_done[d]  = 1'b1;
          end else begin
            m_p[d]++;
          end
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      chk("busy", d, int'(bz[d]), int'(m_busy[d]));
      chk("out_valid", d, int'(vl[d]), int'(m_valid[d]));
      chk("done", d, int'(dn[d]), int'(m_done[d]));
      chk("out_last", d, int'(ls[d]),
          int'(m_valid[d] && m_p[d] == nsz(d) - 1));
      if (m_valid[d]) chk("out_data", d, dat(d), expv[d][m_p[d]]);
      if (hold_v[d] && !reset) chk("stall_stable", d, dat(d), hold_dat[d]);
    end
  end

  // Random backpressure on the N=16 instance, with a 5-cycle stall at p=7.
  always @(negedge clk) begin
    if (!bp_on) begin
      rdy1 = 1'b1;
      held = 1'b0;
      hold_cnt = 0;
    end else if (m_valid[1] && m_p[1] == 7 && !held) begin
      held = 1'b1;
      hold_cnt = 4;
      rdy1 = 1'b0;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
      rdy1 = 1'b0;
    end else begin
      rdy1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic load(int d, logic [31:0] s);
    @(negedge clk);
    seed = s;
    sl[d] = 1'b1;
    @(negedge clk);
    sl[d] = 1'b0;
  endtask

  task automatic run(int d, bit poke);
    int first = -1;
    bit got = 1'b0;
    int n = nsz(d);
    bit [15:0] seen = '0;
    bit ok = 1'b1;
    int v;
    rec_n[d] = 0;
    last_n[d] = 0;
    last_at[d] = 0;
    done_n[d] = 0;
    @(negedge clk);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    for (int c = 1; c <= 16 * n + 40; c++) begin
      if (poke && c == 3) begin
        seed = 32'h1234_5678;
        st[d] = 1'b1;
        sl[d] = 1'b1;
      end
      if (poke && c == 4) begin
        st[d] = 1'b0;
        sl[d] = 1'b0;
      end
      if (vl[d] && first < 0) first = c;
      if (dn[d]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("run_completes", d, int'(got), 1);
    @(negedge clk);
    chk("latency_min", d, int'(first >= 2 * n), 1);
    chk("xfers", d, rec_n[d], n);
    for (int k = 0; k < n && k < rec_n[d]; k++) begin
      v = rec[d][k];
      if (v >= n || seen[v]) ok = 1'b0;
      else seen[v] = 1'b1;
    end
    chk("perm_set", d, int'(ok), 1);
    chk("last_count", d, last_n[d], 1);
    chk("last_pos", d, last_at[d], n);
    chk("done_pulses", d, done_n[d], 1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sa [8];
    int sb [8];
    int dif, dr;
    bit s01, s10;
    #1;
    chk("pin_lfsr_1", 0, int'(lnext(32'h1)), 3);
    chk("pin_lfsr_3", 0, int'(lnext(32'h3)), 6);
    chk("pin_lfsr_ace1", 0, int'(lnext(32'hACE1)), 32'h159C3);
    chk("pin_mask5", 0, msk(5), 7);
    chk("pin_mask4", 0, msk(4), 7);
    chk("pin_mask3", 0, msk(3), 3);
    chk("pin_mask1", 0, msk(1), 1);
    m_lfsr[3] = 32'h1;
    dr = gen(3);
    chk("pin_n2_s1_draws", 3, dr, 1);
    chk("pin_n2_s1_e0", 3, expv[3][0], 0);
    chk("pin_n2_s1_e1", 3, expv[3][1], 1);
    m_lfsr[3] = 32'h2;
    dr = gen(3);
    chk("pin_n2_s2_e0", 3, expv[3][0], 1);
    chk("pin_n2_s2_e1", 3, expv[3][1], 0);
    #1;
    chk("rst_busy", 0, int'(bz), 0);
    chk("rst_valid", 0, int'(vl), 0);
    chk("rst_last", 0, int'(ls), 0);
    chk("rst_done", 0, int'(dn), 0);
    chk("rst_data8", 0, int'(d0), 0);
    chk("rst_data16", 1, int'(d1), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    load(0, 32'h1);
    run(0, 1'b0);

    load(0, 32'hDEADBEEF);
    run(0, 1'b0);
    for (int k = 0; k < 8; k++) sa[k] = rec[0][k];
    load(0, 32'hDEADBEEF);
    run(0, 1'b0);
    dif = 0;
    for (int k = 0; k < 8; k++) if (rec[0][k] != sa[k]) dif++;
    chk("reload_same_seq", 0, dif, 0);
    run(0, 1'b0);
    dif = 0;
    for (int k = 0; k < 8; k++) if (rec[0][k] != sa[k]) dif++;
    chk("no_reload_differs", 0, int'(dif > 0), 1);

    load(0, 32'h0);
    run(0, 1'b0);
    for (int k = 0; k < 8; k++) sb[k] = rec[0][k];
    load(0, 32'hACE1);
    run(0, 1'b0);
    dif = 0;
    for (int k = 0; k < 8; k++) if (rec[0][k] != sb[k]) dif++;
    chk("zero_seed_default", 0, dif, 0);

    load(0, 32'h5);
    run(0, 1'b1);

    bp_on = 1'b1;
    load(1, $urandom | 32'h1);
    run(1, 1'b0);
    bp_on = 1'b0;
    @(negedge clk);
    bp_on = 1'b1;
    run(1, 1'b0);
    bp_on = 1'b0;

    run(2, 1'b0);
    chk("n1_elem", 2, rec[2][0], 0);

    s01 = 1'b0;
    s10 = 1'b0;
    for (int s = 1; s <= 100; s++) begin
      load(3, 32'(s));
      run(3, 1'b0);
      if (rec[3][0] == 0) s01 = 1'b1;
      else s10 = 1'b1;
    end
    chk("n2_order_01", 3, int'(s01), 1);
    chk("n2_order_10", 3, int'(s10), 1);

    load(0, 32'h7);
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", 0, int'(bz[0]), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_busy", 0, int'(bz[0]), 0);
    chk("async_rst_valid", 0, int'(vl[0]), 0);
    chk("async_rst_done", 0, int'(dn[0]), 0);
    chk("async_rst_data", 0, int'(d0), 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
